// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains bytes from an upstream registered-read FIFO and sends
// them as UART frames, 8 data bits LSB first with one stop bit.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between DATA and STOP (11-bit frames instead of 8N1).
// All outputs are decoded from registered state only.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    // State, baud counter, bit index and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic parity_q;

    // Even parity of the byte, captured alongside the shift register load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (state_q == LOAD) begin
            parity_q <= ^fifo_data;
        end
    end
`endif

    // Next-state logic; each line bit lasts CLKS_PER_BIT cycles
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                shreg_d = fifo_data;
                baud_d  = '0;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from registered state
    always_comb begin
        fifo_rd_en = (state_q == FETCH);
        busy       = (state_q != IDLE);
        tx_done    = (state_q == STOP) && baud_end;
        tx         = 1'b1;
        case (state_q)
            START:  tx = 1'b0;
            DATA:   tx = shreg_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx = parity_q;
`endif
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed scenarios for fifo_uart_tx with CLKS_PER_BIT=4.
// A small FIFO model feeds the DUT; expected bytes go into a scoreboard
// queue when written to the FIFO and are popped as frames are decoded.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS   = 11;
    localparam int EXP_LAT = 47;
`else
    localparam int NBITS   = 10;
    localparam int EXP_LAT = 43;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data = '0;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    // FIFO model: write side owned by the stimulus, read side by this block
    logic [7:0] mem [0:31];
    logic [4:0] wr_ptr = '0;
    logic [4:0] rd_ptr = '0;
    logic       hold_empty = 1'b0;
    int         rd_count = 0;
    int         viol_count = 0;

    assign fifo_empty = hold_empty || (wr_ptr == rd_ptr);

    // Registered read data plus strobe bookkeeping
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 5'd1;
            rd_count  <= rd_count + 1;
            if (fifo_empty) viol_count <= viol_count + 1;
        end
    end

    int         vectors = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];

    task automatic push_byte(input logic [7:0] b, input bit expect_frame);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 5'd1;
        if (expect_frame) exp_q.push_back(b);
    endtask

    // Decode one frame from tx sampled on falling edges
    task automatic rx_frame(input bit toggle, output logic [7:0] data, output logic par,
                            output int bad, output int dones, output logic done_last,
                            output int idle, output int lat, output bit tmo);
        int   n;
        logic lvl;
        bad = 0; dones = 0; idle = 0; lat = 0; tmo = 1'b0;
        data = '0; par = 1'b0; done_last = 1'b0; lvl = 1'b1;
        n = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (tx === 1'b0) break;
            idle++;
        end
        if (tx !== 1'b0) begin
            tmo = 1'b1;
            return;
        end
        if (toggle) hold_empty = 1'b1;
        for (int b = 0; b < NBITS; b++) begin
            for (int s = 0; s < CPB; s++) begin
                if (!(b == 0 && s == 0)) begin
                    @(negedge clk);
                    n++;
                end
                if (toggle && b == 0 && s == 2) hold_empty = 1'b0;
                if (s == 0) lvl = tx;
                else if (tx !== lvl) bad++;
                if (tx_done === 1'b1) begin
                    dones++;
                    if (lat == 0) lat = n;
                end
                if (b == NBITS - 1 && s == CPB - 1) done_last = tx_done;
            end
            if (b == 0 && lvl !== 1'b0) bad++;
            if (b >= 1 && b <= 8) data = {lvl, data[7:1]};
            if (NBITS == 11 && b == 9) par = lvl;
            if (b == NBITS - 1 && lvl !== 1'b1) bad++;
        end
    endtask

    task automatic test_reset;
        int bad;
        repeat (3) @(negedge clk);
        vectors++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
        vectors++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done: got %b expected 0", tx_done); end
        rst_n = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
        end
        vectors++; if (bad != 0) begin errors++; $display("FAIL idle_50: got %0d bad cycles expected 0", bad); end
        vectors++; if (rd_count != 0) begin errors++; $display("FAIL idle_reads: got %0d expected 0", rd_count); end
    endtask

    task automatic test_single;
        logic [7:0] d; logic p, dl; int bad, dn, idl, lat, rd0; bit tmo;
        logic [7:0] e;
        rd0 = rd_count;
        push_byte(8'h55, 1'b1);
        rx_frame(1'b0, d, p, bad, dn, dl, idl, lat, tmo);
        e = exp_q.pop_front();
        vectors++; if (tmo) begin errors++; $display("FAIL single_timeout: got none expected frame"); end
        vectors++; if (d !== e) begin errors++; $display("FAIL single_data: got %02h expected %02h", d, e); end
        vectors++; if (bad != 0) begin errors++; $display("FAIL single_levels: got %0d bad expected 0", bad); end
        vectors++; if (dn != 1 || dl !== 1'b1) begin errors++; $display("FAIL single_done: got %0d/%b expected 1/1", dn, dl); end
        vectors++; if (lat != EXP_LAT) begin errors++; $display("FAIL single_latency: got %0d expected %0d", lat, EXP_LAT); end
        @(negedge clk);
        vectors++; if (rd_count - rd0 != 1) begin errors++; $display("FAIL single_reads: got %0d expected 1", rd_count - rd0); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d; logic p, dl; int bad, dn, idl, lat, rd0; bit tmo;
        logic [7:0] e;
        rd0 = rd_count;
        push_byte(8'hA3, 1'b1);
        push_byte(8'h0F, 1'b1);
        for (int k = 0; k < 2; k++) begin
            rx_frame(1'b0, d, p, bad, dn, dl, idl, lat, tmo);
            e = exp_q.pop_front();
            vectors++; if (tmo || d !== e) begin errors++; $display("FAIL b2b_data%0d: got %02h expected %02h", k, d, e); end
            vectors++; if (bad != 0 || dn != 1) begin errors++; $display("FAIL b2b_frame%0d: got bad=%0d done=%0d expected 0/1", k, bad, dn); end
            if (k == 1) begin
                vectors++; if (idl != 3) begin errors++; $display("FAIL b2b_gap: got %0d expected 3", idl); end
            end
        end
        repeat (4) @(negedge clk);
        vectors++; if (rd_count - rd0 != 2 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end: got reads=%0d busy=%b expected 2/0", rd_count - rd0, busy); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [7:0] d; logic p, dl; int bad, dn, idl, lat; bit tmo;
        logic [7:0] e;
        logic       ep [2];
        ep[0] = 1'b1;
        ep[1] = 1'b0;
        push_byte(8'h07, 1'b1);
        push_byte(8'h03, 1'b1);
        for (int k = 0; k < 2; k++) begin
            rx_frame(1'b0, d, p, bad, dn, dl, idl, lat, tmo);
            e = exp_q.pop_front();
            vectors++; if (tmo || d !== e) begin errors++; $display("FAIL par_data%0d: got %02h expected %02h", k, d, e); end
            vectors++; if (p !== ep[k]) begin errors++; $display("FAIL par_bit%0d: got %b expected %b", k, p, ep[k]); end
            vectors++; if (bad != 0 || dl !== 1'b1) begin errors++; $display("FAIL par_frame%0d: got bad=%0d done=%b expected 0/1", k, bad, dl); end
        end
        repeat (4) @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid_frame;
        int bad, rd0;
        push_byte(8'hFF, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx === 1'b0) break;
        end
        vectors++; if (tx !== 1'b0) begin errors++; $display("FAIL rst_mid_start: got %b expected 0", tx); end
        repeat (CPB * 4) @(negedge clk);
        vectors++; if (busy !== 1'b1 || tx !== 1'b1) begin errors++; $display("FAIL rst_mid_bit3: got busy=%b tx=%b expected 1/1", busy, tx); end
        rd0 = rd_count;
        rst_n = 1'b0;
        #1;
        vectors++; if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async: got tx=%b busy=%b done=%b rd=%b expected 1/0/0/0", tx, busy, tx_done, fifo_rd_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        vectors++; if (bad != 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d bad cycles expected 0", bad); end
        vectors++; if (rd_count != rd0) begin errors++; $display("FAIL rst_mid_reread: got %0d reads expected %0d", rd_count, rd0); end
    endtask

    task automatic test_empty_toggle;
        logic [7:0] d; logic p, dl; int bad, dn, idl, lat, rd0; bit tmo;
        logic [7:0] e;
        rd0 = rd_count;
        push_byte(8'h5A, 1'b1);
        push_byte(8'hC3, 1'b1);
        rx_frame(1'b1, d, p, bad, dn, dl, idl, lat, tmo);
        e = exp_q.pop_front();
        vectors++; if (tmo || d !== e) begin errors++; $display("FAIL tog_data: got %02h expected %02h", d, e); end
        vectors++; if (bad != 0 || dn != 1) begin errors++; $display("FAIL tog_frame: got bad=%0d done=%0d expected 0/1", bad, dn); end
        vectors++; if (rd_count - rd0 != 1) begin errors++; $display("FAIL tog_reads: got %0d expected 1", rd_count - rd0); end
        rx_frame(1'b0, d, p, bad, dn, dl, idl, lat, tmo);
        e = exp_q.pop_front();
        vectors++; if (tmo || d !== e) begin errors++; $display("FAIL tog_next: got %02h expected %02h", d, e); end
        repeat (20) @(negedge clk);
        vectors++; if (rd_count - rd0 != 2 || viol_count != 0) begin
            errors++; $display("FAIL tog_total: got reads=%0d viol=%0d expected 2/0", rd_count - rd0, viol_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        test_empty_toggle();
        vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d expected 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have one parameter, listed as name, default, meaning: CLKS_PER_BIT, 434, clock cycles per UART bit period (legal range 2..65535).
REQ-002 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- fifo_empty  in  1  upstream FIFO empty flag.
- fifo_data  in  8  upstream FIFO registered read data; valid the cycle after a read strobe.
- fifo_rd_en  out  1  read strobe to the FIFO.
- tx  out  1  serial line; idle high.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse at the end of each frame.
REQ-003 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path.

Function
REQ-004 The FSM SHALL have the states IDLE, FETCH, LOAD, START, DATA, PARITY and STOP.
REQ-005 IDLE SHALL go to FETCH when fifo_empty=0, and SHALL otherwise remain in IDLE.
REQ-006 fifo_rd_en SHALL be high exactly during the single FETCH cycle; FETCH SHALL always go to LOAD.
REQ-007 LOAD SHALL capture fifo_data into an 8-bit shift register and go to START; fifo_data SHALL be ignored in all other states.
REQ-008 START, each DATA bit, PARITY and STOP SHALL each last exactly CLKS_PER_BIT cycles, timed by a 16-bit baud counter.
REQ-009 Line levels SHALL be as follows:
- START drives tx=0.
- DATA sends 8 bits LSB first.
- STOP drives tx=1.
- IDLE, FETCH and LOAD drive tx=1.
REQ-010 A 3-bit bit index SHALL leave DATA after bit 7 completes, going to PARITY when enabled (REQ-018) and to STOP otherwise.
REQ-011 tx_done SHALL pulse high for one cycle on the last cycle of STOP; the FSM SHALL then enter IDLE.
REQ-012 With the FIFO continuously non-empty, exactly 3 tx-high cycles (IDLE, FETCH, LOAD) SHALL separate the end of STOP from the next START.
REQ-013 The first START cycle SHALL occur 3 cycles after IDLE samples fifo_empty=0.
REQ-014 fifo_empty changes after FETCH SHALL NOT affect the frame in progress; there SHALL be no abort and no re-read.
REQ-015 The block SHALL never assert fifo_rd_en while fifo_empty=1 in the same cycle; FETCH is entered only from IDLE with fifo_empty=0.

Reset
REQ-016 While rst_n=0, the block SHALL asynchronously force the following, independent of clk:
- state=IDLE, tx=1, fifo_rd_en=0, busy=0, tx_done=0.
- baud counter, bit index and shift register = 0.
REQ-017 A reset asserted mid-frame SHALL abandon the byte, with no FIFO re-read; after deassertion, operation SHALL resume from IDLE on the first rising edge.

Configuration
REQ-018 Macro UART_TX_PARITY_EN:
- Defined: PARITY is entered after DATA and drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame = 11 bits.
- Undefined: PARITY is unreachable and no parity logic is synthesised; DATA goes directly to STOP; frame = 10 bits (8N1).

Verification
REQ-019 A bench SHALL cover these directed scenarios (CLKS_PER_BIT=4):
- Reset with fifo_empty=1 -> tx=1, busy=0, fifo_rd_en never asserted for 50 cycles.
- FIFO holds 0x55, no parity -> one fifo_rd_en pulse; tx = 0,1,0,1,0,1,0,1,0,1, each level 4 cycles; tx_done once; 43 cycles from fifo_empty=0 to tx_done.
- FIFO holds 0xA3,0x0F back-to-back -> two frames with exactly 3 high cycles between them; decoded bytes 0xA3 then 0x0F.
- UART_TX_PARITY_EN defined, bytes 0x07 and 0x03 -> parity bits 1 and 0 respectively; 11 bits per frame.
- rst_n pulled low during DATA bit 3 of 0xFF -> tx=1 before the next clk edge; after release, no frame starts while fifo_empty=1.
- fifo_empty toggled to 1 during START -> frame completes unchanged; no extra fifo_rd_en.
